// File: rtl/interrupt_ack_sequencer_pkg.sv
// Shared definitions for the interrupt controller: rotation helpers, OCW2 command codes
// and the acknowledge-sequencer state encoding.
package pic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK1 = 2'd1,
        GAP  = 2'd2,
        ACK2 = 2'd3
    } ack_state_t;

    // OCW2 {R,SL,EOI} command codes
    localparam logic [2:0] EOI_NS  = 3'b001;
    localparam logic [2:0] EOI_SP  = 3'b011;
    localparam logic [2:0] ROT_NS  = 3'b101;
    localparam logic [2:0] ROT_SP  = 3'b111;
    localparam logic [2:0] SET_PRI = 3'b110;

    function automatic logic [7:0] rotate(input logic [7:0] value, input logic [2:0] amount);
        logic [15:0] doubled;
        doubled = {value, value} >> amount;
        return doubled[7:0];
    endfunction

    function automatic logic [7:0] un_rotate(input logic [7:0] value, input logic [2:0] amount);
        logic [15:0] doubled;
        doubled = {value, value} << amount;
        return doubled[15:8];
    endfunction

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic logic [2:0] encode(input logic [7:0] bits);
        logic [2:0] idx;
        idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (bits[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/interrupt_ack_sequencer_isr_priority_select.sv
// Finds the highest-priority in-service level under the current rotation.
// Level `rotate` is the lowest priority, so the search starts just above it.
module isr_priority_select (
    input  logic [7:0] isr,
    input  logic [2:0] rotate,
    output logic [7:0] highest_onehot,
    output logic [2:0] highest_level,
    output logic       valid
);

    logic [2:0] shift;
    logic [7:0] rotated;
    logic [2:0] rotated_idx;

    always_comb begin
        shift          = rotate + 3'd1;
        rotated        = pic_pkg::rotate(isr, shift);
        rotated_idx    = pic_pkg::encode(rotated);
        valid          = |isr;
        highest_level  = rotated_idx + shift;
        highest_onehot = valid ? pic_pkg::un_rotate(8'b1 << rotated_idx, shift) : 8'h00;
    end

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// 8086-mode INTA handshake, in-service register and priority rotation for the interrupt
// controller; also decodes OCW2 end-of-interrupt and rotate commands.
module interrupt_ack_sequencer
    import pic_pkg::*;
#(
    parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] interrupt,
    input  logic       inta_n,
    input  logic [4:0] vector_base,
    input  logic       auto_eoi,
    input  logic       rotate_in_aeoi,
    input  logic       eoi_valid,
    input  logic [2:0] eoi_cmd,
    input  logic [2:0] eoi_level,
    output logic       int_out,
    output logic [7:0] in_service_register,
    output logic [7:0] clear_irr,
    output logic       freeze,
    output logic [2:0] priority_rotate,
    output logic [7:0] data_out,
    output logic       data_out_en
);

    ack_state_t state, state_next;
    logic       inta_n_d;
    logic       fall, rise;
    logic [2:0] level, level_next;
    logic       spurious, spurious_next;
    logic       int_next, freeze_next, data_en_next;
    logic [7:0] clear_next, data_next;
    logic [7:0] ack_set, aeoi_clr, eoi_clr, isr_next;
    logic       aeoi_rotate, eoi_rotate;
    logic [2:0] eoi_rot_level, rot_next, ack_level;
    logic [7:0] hp_onehot;
    logic [2:0] hp_level;
    logic       hp_valid;

    assign fall = !inta_n && inta_n_d;
    assign rise = inta_n && !inta_n_d;

    isr_priority_select u_priority_select (
        .isr            (in_service_register),
        .rotate         (priority_rotate),
        .highest_onehot (hp_onehot),
        .highest_level  (hp_level),
        .valid          (hp_valid)
    );

    // A fall seen in ACK1 or GAP is taken as the second pulse.
    always_comb begin
        state_next    = state;
        level_next    = level;
        spurious_next = spurious;
        int_next      = 1'b0;
        freeze_next   = freeze;
        data_next     = data_out;
        data_en_next  = data_out_en;
        clear_next    = 8'h00;
        ack_set       = 8'h00;
        aeoi_clr      = 8'h00;
        aeoi_rotate   = 1'b0;
        ack_level     = encode(interrupt);
        case (state)
            IDLE: begin
                int_next = |interrupt;
                if (fall) begin
                    int_next    = 1'b0;
                    freeze_next = 1'b1;
                    state_next  = ACK1;
                    if (interrupt == 8'h00) begin
                        level_next    = SPURIOUS_LEVEL;
                        spurious_next = 1'b1;
                    end else begin
                        level_next    = ack_level;
                        spurious_next = 1'b0;
                        ack_set       = 8'b1 << ack_level;
                        clear_next    = 8'b1 << ack_level;
                    end
                end
            end
            ACK1, GAP: begin
                if (fall) begin
                    state_next   = ACK2;
                    data_next    = {vector_base, level};
                    data_en_next = 1'b1;
                end else if (rise) begin
                    state_next = GAP;
                end
            end
            ACK2: begin
                if (rise) begin
                    state_next   = IDLE;
                    data_en_next = 1'b0;
                    freeze_next  = 1'b0;
                    if (auto_eoi && !spurious) begin
                        aeoi_clr    = 8'b1 << level;
                        aeoi_rotate = rotate_in_aeoi;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // OCW2 commands act in any state; an EOI rotation overrides an AEOI rotation.
    always_comb begin
        eoi_clr       = 8'h00;
        eoi_rotate    = 1'b0;
        eoi_rot_level = priority_rotate;
        if (eoi_valid) begin
            case (eoi_cmd)
                EOI_NS: eoi_clr = hp_onehot;
                EOI_SP: eoi_clr = 8'b1 << eoi_level;
                ROT_NS: begin
                    if (hp_valid) begin
                        eoi_clr       = hp_onehot;
                        eoi_rotate    = 1'b1;
                        eoi_rot_level = hp_level;
                    end
                end
                ROT_SP: begin
                    eoi_clr       = 8'b1 << eoi_level;
                    eoi_rotate    = 1'b1;
                    eoi_rot_level = eoi_level;
                end
                SET_PRI: begin
                    eoi_rotate    = 1'b1;
                    eoi_rot_level = eoi_level;
                end
                default: ;
            endcase
        end
        isr_next = (in_service_register & ~eoi_clr & ~aeoi_clr) | ack_set;
        if (eoi_rotate) begin
            rot_next = eoi_rot_level;
        end else if (aeoi_rotate) begin
            rot_next = level;
        end else begin
            rot_next = priority_rotate;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state               <= IDLE;
            inta_n_d            <= 1'b1;
            level               <= 3'd0;
            spurious            <= 1'b0;
            int_out             <= 1'b0;
            in_service_register <= 8'h00;
            clear_irr           <= 8'h00;
            freeze              <= 1'b0;
            priority_rotate     <= 3'b111;
            data_out            <= 8'h00;
            data_out_en         <= 1'b0;
        end else begin
            state               <= state_next;
            inta_n_d            <= inta_n;
            level               <= level_next;
            spurious            <= spurious_next;
            int_out             <= int_next;
            in_service_register <= isr_next;
            clear_irr           <= clear_next;
            freeze              <= freeze_next;
            priority_rotate     <= rot_next;
            data_out            <= data_next;
            data_out_en         <= data_en_next;
        end
    end

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Directed self-checking bench for interrupt_ack_sequencer: INTA handshakes, EOI commands,
// spurious acknowledge, auto-EOI rotation and reset in the middle of a handshake.
module tb_interrupt_ack_sequencer;
    import pic_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] interrupt;
    logic       inta_n;
    logic [4:0] vector_base;
    logic       auto_eoi;
    logic       rotate_in_aeoi;
    logic       eoi_valid;
    logic [2:0] eoi_cmd;
    logic [2:0] eoi_level;
    logic       int_out;
    logic [7:0] in_service_register;
    logic [7:0] clear_irr;
    logic       freeze;
    logic [2:0] priority_rotate;
    logic [7:0] data_out;
    logic       data_out_en;

    int checks = 0;
    int errors = 0;

    interrupt_ack_sequencer dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .interrupt           (interrupt),
        .inta_n              (inta_n),
        .vector_base         (vector_base),
        .auto_eoi            (auto_eoi),
        .rotate_in_aeoi      (rotate_in_aeoi),
        .eoi_valid           (eoi_valid),
        .eoi_cmd             (eoi_cmd),
        .eoi_level           (eoi_level),
        .int_out             (int_out),
        .in_service_register (in_service_register),
        .clear_irr           (clear_irr),
        .freeze              (freeze),
        .priority_rotate     (priority_rotate),
        .data_out            (data_out),
        .data_out_en         (data_out_en)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic inta_value, input int cycles);
        inta_n = inta_value;
        repeat (cycles) tick();
    endtask

    task automatic issueEoi(input logic [2:0] cmd, input logic [2:0] lvl);
        eoi_valid = 1'b1;
        eoi_cmd   = cmd;
        eoi_level = lvl;
        tick();
        eoi_valid = 1'b0;
    endtask

    task automatic runAck(input logic [7:0] req);
        interrupt = req;
        tick();
        applyStimulus(1'b0, 1);
        interrupt = 8'h00;
        applyStimulus(1'b0, 1);
        applyStimulus(1'b1, 1);
        applyStimulus(1'b0, 2);
        applyStimulus(1'b1, 1);
    endtask

    task automatic checkReset(input string tag);
        $display("[TB] checking reset values (%s)", tag);
        checkOutput("rst_int_out", 32'(int_out), 32'd0);
        checkOutput("rst_isr", 32'(in_service_register), 32'h00);
        checkOutput("rst_clear_irr", 32'(clear_irr), 32'h00);
        checkOutput("rst_freeze", 32'(freeze), 32'd0);
        checkOutput("rst_rotate", 32'(priority_rotate), 32'd7);
        checkOutput("rst_data_out", 32'(data_out), 32'h00);
        checkOutput("rst_data_en", 32'(data_out_en), 32'd0);
    endtask

    initial begin
        rst_n          = 1'b0;
        interrupt      = 8'h00;
        inta_n         = 1'b1;
        vector_base    = 5'h10;
        auto_eoi       = 1'b0;
        rotate_in_aeoi = 1'b0;
        eoi_valid      = 1'b0;
        eoi_cmd        = 3'b000;
        eoi_level      = 3'd0;
        tick();
        tick();
        checkReset("power-on");
        rst_n = 1'b1;
        tick();

        $display("[TB] basic handshake on IR3");
        interrupt = 8'h08;
        checkOutput("int_before_edge", 32'(int_out), 32'd0);
        tick();
        checkOutput("int_latency", 32'(int_out), 32'd1);
        applyStimulus(1'b0, 1);
        checkOutput("ack1_isr", 32'(in_service_register), 32'h08);
        checkOutput("ack1_clear_irr", 32'(clear_irr), 32'h08);
        checkOutput("ack1_freeze", 32'(freeze), 32'd1);
        checkOutput("ack1_int_out", 32'(int_out), 32'd0);
        interrupt = 8'h00;
        applyStimulus(1'b0, 1);
        checkOutput("clear_irr_pulse_end", 32'(clear_irr), 32'h00);
        applyStimulus(1'b1, 1);
        checkOutput("gap_freeze", 32'(freeze), 32'd1);
        applyStimulus(1'b0, 1);
        checkOutput("ack2_data", 32'(data_out), 32'h83);
        checkOutput("ack2_data_en", 32'(data_out_en), 32'd1);
        applyStimulus(1'b0, 1);
        checkOutput("ack2_data_en_hold", 32'(data_out_en), 32'd1);
        applyStimulus(1'b1, 1);
        checkOutput("end_data_en", 32'(data_out_en), 32'd0);
        checkOutput("end_freeze", 32'(freeze), 32'd0);
        checkOutput("end_isr", 32'(in_service_register), 32'h08);

        $display("[TB] EOI commands under fixed and rotated priority");
        runAck(8'h02);
        checkOutput("isr_0a", 32'(in_service_register), 32'h0A);
        issueEoi(EOI_NS, 3'd0);
        checkOutput("ns_eoi_isr", 32'(in_service_register), 32'h08);
        issueEoi(ROT_SP, 3'd3);
        checkOutput("rot_sp_isr", 32'(in_service_register), 32'h00);
        checkOutput("rot_sp_rotate", 32'(priority_rotate), 32'd3);
        runAck(8'h01);
        runAck(8'h80);
        checkOutput("isr_81", 32'(in_service_register), 32'h81);
        issueEoi(EOI_NS, 3'd0);
        checkOutput("ns_eoi_rotated", 32'(in_service_register), 32'h01);
        issueEoi(EOI_SP, 3'd0);
        checkOutput("sp_eoi_isr", 32'(in_service_register), 32'h00);
        issueEoi(ROT_NS, 3'd5);
        checkOutput("rot_ns_empty_rotate", 32'(priority_rotate), 32'd3);
        issueEoi(SET_PRI, 3'd7);
        checkOutput("set_pri_rotate", 32'(priority_rotate), 32'd7);

        $display("[TB] spurious acknowledge");
        interrupt = 8'h00;
        applyStimulus(1'b0, 1);
        checkOutput("spur_freeze", 32'(freeze), 32'd1);
        checkOutput("spur_isr", 32'(in_service_register), 32'h00);
        checkOutput("spur_clear_irr", 32'(clear_irr), 32'h00);
        applyStimulus(1'b1, 1);
        applyStimulus(1'b0, 1);
        checkOutput("spur_data", 32'(data_out), 32'h87);
        checkOutput("spur_data_en", 32'(data_out_en), 32'd1);
        applyStimulus(1'b1, 1);
        checkOutput("spur_end_isr", 32'(in_service_register), 32'h00);

        $display("[TB] auto-EOI with rotation on IR5");
        auto_eoi       = 1'b1;
        rotate_in_aeoi = 1'b1;
        interrupt      = 8'h20;
        tick();
        applyStimulus(1'b0, 1);
        checkOutput("aeoi_isr_set", 32'(in_service_register), 32'h20);
        checkOutput("aeoi_clear_irr", 32'(clear_irr), 32'h20);
        interrupt = 8'h00;
        applyStimulus(1'b1, 1);
        applyStimulus(1'b0, 1);
        checkOutput("aeoi_data", 32'(data_out), 32'h85);
        checkOutput("aeoi_isr_held", 32'(in_service_register), 32'h20);
        applyStimulus(1'b1, 1);
        checkOutput("aeoi_isr_cleared", 32'(in_service_register), 32'h00);
        checkOutput("aeoi_rotate", 32'(priority_rotate), 32'd5);
        auto_eoi       = 1'b0;
        rotate_in_aeoi = 1'b0;

        $display("[TB] reset during GAP, then a fresh request");
        interrupt = 8'h04;
        tick();
        applyStimulus(1'b0, 1);
        checkOutput("pre_reset_isr", 32'(in_service_register), 32'h04);
        applyStimulus(1'b1, 1);
        rst_n = 1'b0;
        tick();
        checkReset("mid-handshake");
        rst_n = 1'b1;
        tick();
        checkOutput("post_reset_int", 32'(int_out), 32'd1);
        applyStimulus(1'b0, 1);
        checkOutput("post_reset_isr", 32'(in_service_register), 32'h04);
        checkOutput("post_reset_clear_irr", 32'(clear_irr), 32'h04);
        interrupt = 8'h00;
        applyStimulus(1'b1, 1);
        applyStimulus(1'b0, 1);
        checkOutput("post_reset_data", 32'(data_out), 32'h82);
        applyStimulus(1'b1, 1);
        checkOutput("post_reset_data_en", 32'(data_out_en), 32'd0);
        checkOutput("post_reset_freeze", 32'(freeze), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
